// File: rtl/mode_counter_pkg.sv
// mode_counter shared types: mode encodings and one-shot FSM states.
package mode_counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/mode_counter_prescaler.sv
// Enabled-cycle prescaler; tick fires on the last enabled cycle of a period.
module mode_counter_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;

  assign tick = enable && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear)
      cnt <= '0;
    else if (tick)
      cnt <= '0;
    else if (enable)
      cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/mode_counter.sv
// Up/down counter with wrap, saturate and one-shot modes,
// prescaled stepping, terminal-count pulse and sticky overflow.
module mode_counter
  import mode_counter_pkg::*;
#(
  parameter int          WIDTH     = 4,
  parameter int unsigned MAX_COUNT = (2**WIDTH) - 1,
  parameter int          PRESCALE  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_dn,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clear_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             busy
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_COUNT);

  mode_e          md;
  state_e         state;
  state_e         state_nx;
  logic           tick;
  logic           oneshot;
  logic           wrap;
  logic           live;
  logic           step;
  logic           at_bound;
  logic           bstep;
  logic [WIDTH-1:0] count_nx;

  mode_counter_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_pre (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .clear (load),
    .tick  (tick)
  );

  assign md       = mode_e'(mode);
  assign oneshot  = (md == MODE_ONESHOT);
  assign wrap     = (md == MODE_WRAP) || (md == MODE_RSVD);
  // one-shot only counts while running
  assign live     = !oneshot || (state == ST_RUN);
  assign step     = tick && !load && live;
  assign at_bound = up_dn ? (count == MAXV) : (count == '0);
  assign bstep    = step && at_bound;
  assign busy     = (state == ST_RUN);

  always_comb begin
    count_nx = count;
    if (load) begin
      count_nx = (load_value > MAXV) ? MAXV : load_value;
    end else if (step) begin
      if (at_bound) begin
        if (wrap)
          count_nx = up_dn ? '0 : MAXV;
      end else begin
        count_nx = up_dn ? count + WIDTH'(1)
                         : count - WIDTH'(1);
      end
    end
  end

  always_comb begin
    state_nx = state;
    if (!oneshot) begin
      state_nx = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: if (load)  state_nx = ST_RUN;
        ST_RUN:  if (bstep) state_nx = ST_DONE;
        ST_DONE: if (load)  state_nx = ST_RUN;
        default:            state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      count <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      tc    <= bstep;
      ovf   <= bstep | (ovf & ~clear_ovf);
    end
  end

endmodule

// File: tb/tb_mode_counter.sv
// Bench for mode_counter: three parameterisations on shared stimulus,
// directed tables plus random traffic against a behavioural model.
module tb_mode_counter;

  localparam int N = 3;

  logic       clk = 1'b0;
  logic       reset, enable, up_dn, load, clear_ovf;
  logic [1:0] mode;
  logic [3:0] load_value;

  logic [3:0] q_cnt  [N];
  logic       q_tc   [N];
  logic       q_ovf  [N];
  logic       q_busy [N];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mode_counter #(.WIDTH(4), .MAX_COUNT(15), .PRESCALE(1)) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn),
    .mode(mode), .load(load), .load_value(load_value),
    .clear_ovf(clear_ovf), .count(q_cnt[0]), .tc(q_tc[0]),
    .ovf(q_ovf[0]), .busy(q_busy[0]));

  mode_counter #(.WIDTH(4), .MAX_COUNT(5), .PRESCALE(1)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn),
    .mode(mode), .load(load), .load_value(load_value),
    .clear_ovf(clear_ovf), .count(q_cnt[1]), .tc(q_tc[1]),
    .ovf(q_ovf[1]), .busy(q_busy[1]));

  mode_counter #(.WIDTH(4), .MAX_COUNT(9), .PRESCALE(3)) dut2 (
    .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn),
    .mode(mode), .load(load), .load_value(load_value),
    .clear_ovf(clear_ovf), .count(q_cnt[2]), .tc(q_tc[2]),
    .ovf(q_ovf[2]), .busy(q_busy[2]));

  // behavioural model, one slot per instance
  int m_cnt [N];
  int m_pre [N];
  bit m_tc  [N];
  bit m_ovf [N];
  bit m_run [N];

  function automatic int maxc(int i);
    return (i == 0) ? 15 : (i == 1) ? 5 : 9;
  endfunction

  function automatic int presc(int i);
    return (i == 2) ? 3 : 1;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < N; i++) begin
      int  m;
      bit  tick, osm, wrapm, live, bnd;
      m = maxc(i);
      if (reset) begin
        m_cnt[i] = 0; m_pre[i] = 0; m_tc[i] = 0;
        m_ovf[i] = 0; m_run[i] = 0;
        continue;
      end
      osm   = (mode == 2'd2);
      wrapm = (mode == 2'd0) || (mode == 2'd3);
      tick  = enable && ((m_pre[i] + 1) % presc(i) == 0);
      live  = !osm || m_run[i];
      bnd   = tick && !load && live &&
              (up_dn ? (m_cnt[i] == m) : (m_cnt[i] == 0));
      if (load) m_pre[i] = 0;
      else if (enable) m_pre[i] = (m_pre[i] + 1) % presc(i);
      m_tc[i]  = bnd;
      m_ovf[i] = bnd || (m_ovf[i] && !clear_ovf);
      if (!osm) m_run[i] = 0;
      else if (load) m_run[i] = 1;
      else if (bnd) m_run[i] = 0;
      if (load) begin
        m_cnt[i] = (load_value > m) ? m : int'(load_value);
      end else if (tick && live) begin
        if (up_dn)
          m_cnt[i] = wrapm ? (m_cnt[i] + 1) % (m + 1)
                           : ((m_cnt[i] < m) ? m_cnt[i] + 1 : m);
        else
          m_cnt[i] = wrapm ? (m_cnt[i] + m) % (m + 1)
                           : ((m_cnt[i] > 0) ? m_cnt[i] - 1 : 0);
      end
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("m_cnt%0d", i),  int'(q_cnt[i]),  m_cnt[i]);
      chk($sformatf("m_tc%0d", i),   int'(q_tc[i]),   int'(m_tc[i]));
      chk($sformatf("m_ovf%0d", i),  int'(q_ovf[i]),  int'(m_ovf[i]));
      chk($sformatf("m_busy%0d", i), int'(q_busy[i]), int'(m_run[i]));
    end
  endtask

  task automatic drive(bit r, bit e, bit u, logic [1:0] md,
                       bit l, logic [3:0] lv, bit c);
    reset = r; enable = e; up_dn = u; mode = md;
    load = l; load_value = lv; clear_ovf = c;
  endtask

  typedef struct {
    bit         rst, en, ud;
    logic [1:0] md;
    bit         ld;
    logic [3:0] lv;
    bit         clr;
    int         inst;
    int         cnt;
    bit         tc, ovf, busy;
  } vec_t;

  vec_t tbl [19];

  function automatic vec_t v(bit r, bit e, bit u, logic [1:0] md,
                             bit l, logic [3:0] lv, bit c, int inst,
                             int cnt, bit tc, bit ovf, bit busy);
    vec_t x;
    x.rst = r; x.en = e; x.ud = u; x.md = md; x.ld = l; x.lv = lv;
    x.clr = c; x.inst = inst; x.cnt = cnt; x.tc = tc; x.ovf = ovf;
    x.busy = busy;
    return x;
  endfunction

  initial begin
    // SAT down from 2, sticky ovf, clear (inst 0)
    tbl[0]  = v(1,0,0,2'd1,0, 0,0, 0,  0,0,0,0);
    tbl[1]  = v(0,0,0,2'd1,1, 2,0, 0,  2,0,0,0);
    tbl[2]  = v(0,1,0,2'd1,0, 0,0, 0,  1,0,0,0);
    tbl[3]  = v(0,1,0,2'd1,0, 0,0, 0,  0,0,0,0);
    tbl[4]  = v(0,1,0,2'd1,0, 0,0, 0,  0,1,1,0);
    tbl[5]  = v(0,1,0,2'd1,0, 0,0, 0,  0,1,1,0);
    tbl[6]  = v(0,0,0,2'd1,0, 0,1, 0,  0,0,0,0);
    tbl[7]  = v(0,0,0,2'd1,0, 0,0, 0,  0,0,0,0);
    // ONESHOT up from 3 to MAX_COUNT=5 (inst 1)
    tbl[8]  = v(0,0,1,2'd2,1, 3,0, 1,  3,0,0,1);
    tbl[9]  = v(0,1,1,2'd2,0, 0,0, 1,  4,0,0,1);
    tbl[10] = v(0,1,1,2'd2,0, 0,0, 1,  5,0,0,1);
    tbl[11] = v(0,1,1,2'd2,0, 0,0, 1,  5,1,1,0);
    tbl[12] = v(0,1,1,2'd2,0, 0,0, 1,  5,0,1,0);
    tbl[13] = v(0,1,1,2'd2,0, 0,0, 1,  5,0,1,0);
    // load beats tick, load clamps to MAX_COUNT=9 (inst 2, PRESCALE 3)
    tbl[14] = v(1,0,1,2'd0,0, 0,0, 2,  0,0,0,0);
    tbl[15] = v(0,1,1,2'd0,0, 0,0, 2,  0,0,0,0);
    tbl[16] = v(0,1,1,2'd0,0, 0,0, 2,  0,0,0,0);
    tbl[17] = v(0,1,1,2'd0,1, 7,0, 2,  7,0,0,0);
    tbl[18] = v(0,0,1,2'd0,1,12,0, 2,  9,0,0,0);

    drive(1,0,1,2'd0,0,0,0);
    cycle();
    chk("reset_cnt",  int'(q_cnt[0]),  0);
    chk("reset_tc",   int'(q_tc[0]),   0);
    chk("reset_ovf",  int'(q_ovf[0]),  0);
    chk("reset_busy", int'(q_busy[0]), 0);

    // WRAP up for 20 cycles
    for (int k = 1; k <= 20; k++) begin
      drive(0,1,1,2'd0,0,0,0);
      cycle();
      chk("wrap_cnt", int'(q_cnt[0]), k % 16);
      chk("wrap_tc",  int'(q_tc[0]),  (k == 16) ? 1 : 0);
      chk("wrap_ovf", int'(q_ovf[0]), (k >= 16) ? 1 : 0);
    end

    foreach (tbl[j]) begin
      drive(tbl[j].rst, tbl[j].en, tbl[j].ud, tbl[j].md,
            tbl[j].ld, tbl[j].lv, tbl[j].clr);
      cycle();
      chk($sformatf("tbl%0d_cnt", j),
          int'(q_cnt[tbl[j].inst]), tbl[j].cnt);
      chk($sformatf("tbl%0d_tc", j),
          int'(q_tc[tbl[j].inst]), int'(tbl[j].tc));
      chk($sformatf("tbl%0d_ovf", j),
          int'(q_ovf[tbl[j].inst]), int'(tbl[j].ovf));
      chk($sformatf("tbl%0d_busy", j),
          int'(q_busy[tbl[j].inst]), int'(tbl[j].busy));
    end

    // prescale freeze: 2 enabled, 4 idle, then the 3rd enabled steps
    drive(1,0,1,2'd0,0,0,0);
    cycle();
    drive(0,1,1,2'd0,0,0,0);
    repeat (2) cycle();
    drive(0,0,1,2'd0,0,0,0);
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("frz_cnt", int'(q_cnt[2]), 0);
    end
    drive(0,1,1,2'd0,0,0,0);
    cycle();
    chk("frz_step", int'(q_cnt[2]), 1);
    repeat (2) cycle();
    chk("frz_hold", int'(q_cnt[2]), 1);
    cycle();
    chk("frz_step2", int'(q_cnt[2]), 2);

    // reset aborts a running one-shot at count 4
    drive(0,0,1,2'd2,1,3,0);
    cycle();
    drive(0,1,1,2'd2,0,0,0);
    cycle();
    chk("abort_pre_cnt",  int'(q_cnt[1]),  4);
    chk("abort_pre_busy", int'(q_busy[1]), 1);
    drive(1,1,1,2'd2,0,0,0);
    cycle();
    chk("abort_cnt",  int'(q_cnt[1]),  0);
    chk("abort_busy", int'(q_busy[1]), 0);
    chk("abort_tc",   int'(q_tc[1]),   0);

    // random traffic
    up_dn = 1'b1;
    for (int k = 0; k < 4000; k++) begin
      reset      = ($urandom_range(0, 99) == 0);
      enable     = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) up_dn = ~up_dn;
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      load       = ($urandom_range(0, 11) == 0);
      load_value = 4'($urandom_range(0, 15));
      clear_ovf  = ($urandom_range(0, 15) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mode_counter.md
MODE_COUNTER -- requirements
Module: mode_counter

Interface
REQ-001 The block SHALL use one clock, clk, and a synchronous, active-high reset, reset; no other clock or asynchronous reset SHALL exist.
REQ-002 Parameter WIDTH, default 4: count width in bits, legal range 2..32.
REQ-003 Parameter MAX_COUNT, default 2**WIDTH-1: upper count boundary, legal range 1..2**WIDTH-1.
REQ-004 Parameter PRESCALE, default 1: enabled cycles per count step, legal range 1..256.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 enable  input  1  count-step enable.
REQ-008 up_dn  input  1  direction: 1 = up, 0 = down.
REQ-009 mode  input  2  operating mode: 00 WRAP, 01 SAT, 10 ONESHOT, 11 reserved (treated as WRAP).
REQ-010 load  input  1  load count from load_value.
REQ-011 load_value  input  WIDTH  value to load.
REQ-012 clear_ovf  input  1  clears the sticky overflow flag.
REQ-013 count  output  WIDTH  registered count value.
REQ-014 tc  output  1  registered terminal-count pulse.
REQ-015 ovf  output  1  sticky boundary/overflow flag.
REQ-016 busy  output  1  high while a one-shot is running.

Function
REQ-017 Priority per clock edge SHALL be: reset, then load, then count step.
REQ-018 Prescaler: counts cycles with enable=1, holds when enable=0, and is cleared by reset or load. Its tick SHALL assert on the enabled cycle where it reaches PRESCALE-1, after which it returns to 0. With PRESCALE=1, tick = enable.
REQ-019 A step SHALL occur on a tick with load=0. Direction is sampled on the same edge, so an up_dn change affects the next step.
REQ-020 Load SHALL set count = min(load_value, MAX_COUNT) in the following cycle, in every mode.
REQ-021 Boundary is MAX_COUNT for up and 0 for down. A step attempted at the boundary is a "boundary step".
REQ-022 WRAP boundary step: up goes MAX_COUNT->0, down goes 0->MAX_COUNT. Other steps move count by ±1.
REQ-023 SAT boundary step: count holds at the boundary.
REQ-024 Every boundary step SHALL drive tc=1 for exactly the next cycle and SHALL set ovf. On all other cycles tc SHALL be 0.
REQ-025 ovf SHALL clear the cycle after clear_ovf=1. If a set and a clear occur in the same cycle, the set SHALL win.
REQ-026 ONESHOT uses an FSM with states IDLE, RUN and DONE:
- IDLE->RUN on load.
- In RUN, steps behave as SAT; a boundary step goes RUN->DONE.
- DONE->RUN on load.
- Any state returns to IDLE when mode leaves ONESHOT.
REQ-027 In ONESHOT, count SHALL step only in RUN. In IDLE and DONE, ticks are ignored and produce no tc or ovf.
REQ-028 busy SHALL be 1 exactly while the FSM is in RUN. In non-ONESHOT modes the FSM SHALL be held in IDLE.
REQ-029 Mode changes SHALL take effect on the next edge and SHALL NOT alter count.

Reset
REQ-030 After reset: count=0, tc=0, ovf=0, busy=0, FSM=IDLE, prescaler=0.
REQ-031 Reset asserted mid-operation, including during a one-shot RUN, SHALL abort the operation with no tc pulse.

Structure
REQ-032 Package mode_counter_pkg SHALL hold:
- the mode encodings (WRAP, SAT, ONESHOT, reserved);
- the FSM state enum (IDLE, RUN, DONE).
REQ-033 The prescaler SHALL be the sub-module mode_counter_prescaler (ports clk, reset, enable, clear, tick; parameter PRESCALE).

Verification
All scenarios use WIDTH=4, MAX_COUNT=15, PRESCALE=1 unless stated.
REQ-034 WRAP, up, enable=1 for 20 cycles after reset -> count 0..15,0,1,2,3; tc high one cycle after 15->0; ovf=1.
REQ-035 SAT, down, load 2 then enable=1 -> count 2,1,0,0,0; tc high after each step at 0; ovf=1; clear_ovf -> ovf=0 next cycle.
REQ-036 ONESHOT, MAX_COUNT=5, up, load 3, enable=1 -> sequence:
- busy=1, count 3,4,5;
- the next tick's boundary step gives one tc pulse, busy=0, count held at 5;
- further ticks give no tc.
REQ-037 PRESCALE=3, WRAP, up -> count increments every 3rd enabled cycle; deasserting enable for 4 cycles mid-period freezes both prescaler and count.
REQ-038 Simultaneous load=1 (value 7) and tick -> count=7, not a step. MAX_COUNT=9 with load_value 12 -> count=9.
REQ-039 Reset during ONESHOT RUN at count=4 -> next cycle count=0, busy=0, tc=0, FSM IDLE.
